// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit.
// The negate/abs helpers are written once here so the multiplier can reuse them.
package mdu_pkg;

  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } div_state_t;

  function automatic logic [DIV_WIDTH-1:0] twos_negate(input logic [DIV_WIDTH-1:0] x);
    return ~x + DIV_WIDTH'(1);
  endfunction

  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] x,
                                                   input logic              is_signed);
    return (is_signed && x[DIV_WIDTH-1]) ? twos_negate(x) : x;
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle on magnitudes,
// then a sign fix. Quotient feeds LO, remainder feeds HI.
module mdu_div
  import mdu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] dvd;        // dividend magnitude, shifts out as quotient bits shift in
  logic [WIDTH-1:0] dsr;
  logic             dvd_neg;
  logic             quo_neg;
  logic             dsr_zero;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             last_iter;
  logic [WIDTH-1:0] fix_quo;
  logic [WIDTH-1:0] fix_rem;

  assign shifted   = {part_rem, dvd[WIDTH-1]};
  assign trial     = shifted - {1'b0, dsr};
  assign last_iter = (cnt == CW'(WIDTH));

  // With a zero divisor the remainder magnitude equals |dividend|, so the normal
  // remainder sign fix recovers the raw dividend; only the quotient needs overriding.
  assign fix_quo = dsr_zero ? DIV_ZERO_QUOTIENT : (quo_neg ? twos_negate(dvd) : dvd);
  assign fix_rem = dvd_neg ? twos_negate(part_rem) : part_rem;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = CALC;
      CALC: begin
        busy = 1'b1;
        if (last_iter) state_next = FIX;
      end
      FIX: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      part_rem    <= '0;
      dvd         <= '0;
      dsr         <= '0;
      dvd_neg     <= 1'b0;
      quo_neg     <= 1'b0;
      dsr_zero    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dvd      <= abs_val(dividend, is_signed);
            dsr      <= abs_val(divisor, is_signed);
            dvd_neg  <= is_signed & dividend[WIDTH-1];
            quo_neg  <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            dsr_zero <= (divisor == '0);
            part_rem <= '0;
            cnt      <= '0;
          end
        end
        CALC: begin
          if (!last_iter) begin
            cnt <= cnt + CW'(1);
            if (!trial[WIDTH]) begin
              part_rem <= trial[WIDTH-1:0];
              dvd      <= {dvd[WIDTH-2:0], 1'b1};
            end else begin
              part_rem <= shifted[WIDTH-1:0];
              dvd      <= {dvd[WIDTH-2:0], 1'b0};
            end
          end else begin
            quotient    <= fix_quo;
            remainder   <= fix_rem;
            div_by_zero <= dsr_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_div.sv
// Self-checking bench for mdu_div: directed vectors, handshake corner cases,
// mid-operation reset and randomized operands against an arithmetic reference model.
module tb_mdu_div;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int failures = 0;

  mdu_div #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: MIPS DIV/DIVU via 64-bit arithmetic (truncating division).
  function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint sa, sb, q, r;
    res_t   res;
    if (b == '0) begin
      res.q = '1;
      res.r = a;
      res.z = 1'b1;
      return res;
    end
    if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    res.q = q[W-1:0];
    res.r = r[W-1:0];
    res.z = 1'b0;
    return res;
  endfunction

  // Issues one single-cycle start and observes the outcome (no comparisons here).
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output res_t got, output int lat, output int busy_cycles,
                         output bit held);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
    lat = -1; busy_cycles = 0; held = 1'b0; got = '0;
    for (int n = 1; n <= 60; n++) begin
      if (done) begin
        lat = n - 1;
        got = '{quotient, remainder, div_by_zero};
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    if (lat >= 0) begin
      @(negedge clk);
      held = !done && !busy && ({quotient, remainder, div_by_zero} === got);
    end
  endtask

  task automatic check_run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s);
    res_t got, exp;
    int   lat, bc;
    bit   held;
    exp = ref_div(a, b, s);
    run_div(a, b, s, got, lat, bc, held);
    checks++;
    if (lat !== LAT) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, LAT);
    end
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s result: got q=%h r=%h z=%b want q=%h r=%h z=%b",
               name, got.q, got.r, got.z, exp.q, exp.r, exp.z);
    end
    checks++;
    if (bc !== LAT) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, bc, LAT);
    end
    checks++;
    if (held !== 1'b1) begin
      failures++;
      $display("FAIL %s hold_after_done: got %b want 1", name, held);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1; dividend = 32'd77; divisor = 32'd3;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b z=%b q=%h r=%h want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    check_run("divu_100_7",    32'd100,        32'd7,          1'b0);
    check_run("div_m7_2",      32'hFFFF_FFF9,  32'd2,          1'b1);
    check_run("div_7_m2",      32'd7,          32'hFFFF_FFFE,  1'b1);
    check_run("div_overflow",  32'h8000_0000,  32'hFFFF_FFFF,  1'b1);
    check_run("divu_ovf_ops",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0);
    check_run("divu_5_0",      32'd5,          32'd0,          1'b0);
    check_run("divu_9_3",      32'd9,          32'd3,          1'b0);
    check_run("div_m9_0",      32'hFFFF_FFF7,  32'd0,          1'b1);
    check_run("divu_max_1",    32'hFFFF_FFFF,  32'd1,          1'b0);
    check_run("divu_3_10",     32'd3,          32'd10,         1'b0);
  endtask

  task automatic test_handshake;
    int ndone = 0;
    @(negedge clk);
    start = 1'b1; dividend = 32'd10; divisor = 32'd3; is_signed = 1'b0;
    for (int n = 1; n <= 75; n++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          checks++;
          if (n !== 34 || quotient !== 32'd3 || remainder !== 32'd1) begin
            failures++;
            $display("FAIL handshake_first: got cycle=%0d q=%0d r=%0d want cycle=34 q=3 r=1",
                     n, quotient, remainder);
          end
        end else if (ndone == 2) begin
          checks++;
          if (n !== 69 || quotient !== 32'd10 || remainder !== 32'd0) begin
            failures++;
            $display("FAIL handshake_second: got cycle=%0d q=%0d r=%0d want cycle=69 q=10 r=0",
                     n, quotient, remainder);
          end
        end
      end
      start = (n == 5 || n == 34 || n == 35);
      dividend = start ? 32'd50 : $urandom;
      divisor  = start ? 32'd5  : $urandom;
      is_signed = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (ndone !== 2) begin
      failures++;
      $display("FAIL handshake_done_count: got %0d want 2", ndone);
    end
  endtask

  task automatic test_abort;
    int spurious = 0;
    @(negedge clk);
    start = 1'b1; dividend = 32'd1000; divisor = 32'd10; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy_before: got %b want 1", busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      failures++;
      $display("FAIL abort_outputs: got busy=%b done=%b z=%b q=%h r=%h want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    repeat (40) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d active cycles want 0", spurious);
    end
    check_run("abort_restart", 32'd1000, 32'd10, 1'b0);
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    logic         s;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = s ? -W'($urandom_range(1, 15)) : b;
        3: a = W'($urandom_range(0, 255));
        default: ;
      endcase
      check_run($sformatf("rand_%0d", i), a, b, s);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_handshake();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
